lsu: RTL

Load/store unit in the memory stage of the 32-bit RISC-V core, directly downstream of the ALU. It takes the ALU result as the effective address, together with rs2 store data and funct3, and runs one transaction on a variable-latency data-memory handshake bus. It generates byte enables and returns sign- or zero-extended load data. It stalls the pipeline until the access completes and reports misaligned, illegal and timed-out accesses.

---
 rtl/lsu_if.sv | 31 +++
 rtl/lsu.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/lsu_if.sv
// Data-memory handshake bus between the load/store unit and memory.
// Requests are held until ack; read data is valid with ack.
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// Memory-stage load/store unit: one bus transaction per op,
// byte-lane steering, load extension, error and timeout reporting.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [1:0]  rsp_err,
  output logic [31:0] rsp_rdata,
  lsu_if.master       mem
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [31:0] cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;

  logic        legal;
  logic        misal;
  logic [1:0]  size;
  logic [3:0]  be_d;
  logic [31:0] wd_d;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_v;
  logic        tmo;

  assign size = req_funct3[1:0];

  always_comb begin
    legal = 1'b0;
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_we;
      default:                legal = 1'b0;
    endcase
  end

  assign misal = ((size == 2'b01) && req_addr[0]) ||
                 ((size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_comb begin
    be_d = 4'b0000;
    wd_d = req_wdata;
    unique case (1'b1)
      size == 2'b00: begin
        be_d = 4'b0001 << req_addr[1:0];
        wd_d = {4{req_wdata[7:0]}};
      end
      size == 2'b01: begin
        be_d = req_addr[1] ? 4'b1100 : 4'b0011;
        wd_d = {2{req_wdata[15:0]}};
      end
      size == 2'b10: begin
        be_d = 4'b1111;
        wd_d = req_wdata;
      end
      default: begin
        be_d = 4'b0000;
        wd_d = req_wdata;
      end
    endcase
  end

  assign byte_v = mem.mem_rdata[{off_q, 3'b000} +: 8];
  assign half_v = mem.mem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_v = mem.mem_rdata;
    unique case (f3_q)
      3'b000:  ld_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  ld_v = {{16{half_v[15]}}, half_v};
      3'b100:  ld_v = {24'h0, byte_v};
      3'b101:  ld_v = {16'h0, half_v};
      default: ld_v = mem.mem_rdata;
    endcase
  end

  // A zero parameter never aborts
  assign tmo = (TIMEOUT_CYCLES != 0) &&
               (cnt == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wd_q      <= '0;
      rsp_err   <= 2'b00;
      rsp_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            if (legal && !misal) begin
              state  <= BUS;
              cnt    <= '0;
              f3_q   <= req_funct3;
              off_q  <= req_addr[1:0];
              we_q   <= req_we;
              addr_q <= {req_addr[31:2], 2'b00};
              be_q   <= be_d;
              wd_q   <= wd_d;
            end else begin
              state     <= RESP;
              rsp_err   <= legal ? 2'b01 : 2'b10;
              rsp_rdata <= '0;
            end
          end
        end
        BUS: begin
          if (mem.mem_ack) begin
            state     <= RESP;
            rsp_err   <= 2'b00;
            rsp_rdata <= we_q ? 32'h0 : ld_v;
          end else if (tmo) begin
            state     <= RESP;
            rsp_err   <= 2'b11;
            rsp_rdata <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem.mem_req   = (state == BUS);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wd_q;

  assign rsp_valid = (state == RESP);
  assign stall     = ((state == IDLE) && req_valid) ||
                     (state == BUS);

endmodule
